// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter that shares the single write port of an async FIFO
//   among NUM_REQ requesters in the write-clock domain. One requester is
//   granted at a time. Its valid/data go combinationally to the FIFO write
//   port, and it gets a ready that follows the FIFO full flag.
//
//   Build option: define WR_ARB_BURST_EN to hold a grant for up to MAX_BURST
//   accepted beats. Without it, every accepted beat releases the grant, and
//   the burst counter and MAX_BURST compare are not built.
//
// Ports
//   wr_clk     FIFO write clock; all logic is rising-edge.
//   wr_rst     synchronous active-high reset.
//   req_valid  per-requester data valid.
//   req_data   packed data; requester k at [k*DATA_WIDTH +: DATA_WIDTH].
//   req_ready  per-requester accept; at most one bit high.
//   full       FIFO full flag.
//   wr_valid   FIFO write valid (FIFO writes on wr_valid && !full).
//   wr_data    FIFO write data.
//   gnt_valid  a grant is held.
//   gnt_id     index of the granted requester.
module fifo_wr_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int REQ_IDX_WIDTH   = 2,
  parameter int DATA_WIDTH      = 8,
  parameter int MAX_BURST       = 4,
  parameter int BURST_CNT_WIDTH = 3
) (
  input  logic                          wr_clk,
  input  logic                          wr_rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          full,
  output logic                          wr_valid,
  output logic [DATA_WIDTH-1:0]         wr_data,
  output logic                          gnt_valid,
  output logic [REQ_IDX_WIDTH-1:0]      gnt_id
);

  if (NUM_REQ < 2 || NUM_REQ > 16 || (1 << REQ_IDX_WIDTH) < NUM_REQ) begin : g_bad_req_cfg
    $error("fifo_wr_arbiter: NUM_REQ must be 2..16 and fit in REQ_IDX_WIDTH bits");
  end
  if (MAX_BURST < 1 || MAX_BURST >= (1 << BURST_CNT_WIDTH)) begin : g_bad_burst_cfg
    $error("fifo_wr_arbiter: MAX_BURST must be 1..2**BURST_CNT_WIDTH-1");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                   state_q, state_d;
  logic [REQ_IDX_WIDTH-1:0] gnt_id_q, gnt_id_d;
  logic [REQ_IDX_WIDTH-1:0] last_id_q, last_id_d;

  logic                     pick_found;
  logic [REQ_IDX_WIDTH-1:0] pick_id;
  logic                     cur_valid;
  logic [DATA_WIDTH-1:0]    cur_data;
  logic                     accept;
  logic                     burst_done;

  // Round-robin search starting at last_id+1. Candidates above last_id
  // are tried first, then the wrapped range 0..last_id. Only indices
  // below NUM_REQ exist, so wrapping is at NUM_REQ.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!pick_found && req_valid[k] && (REQ_IDX_WIDTH'(k) > last_id_q)) begin
        pick_found = 1'b1;
        pick_id    = REQ_IDX_WIDTH'(k);
      end
    end
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!pick_found && req_valid[k] && (REQ_IDX_WIDTH'(k) <= last_id_q)) begin
        pick_found = 1'b1;
        pick_id    = REQ_IDX_WIDTH'(k);
      end
    end
  end

  // Granted requester's valid/data and the write-side outputs. These are
  // combinational so data reaches the FIFO with zero latency.
  always_comb begin
    cur_valid = 1'b0;
    cur_data  = '0;
    req_ready = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (gnt_id_q == REQ_IDX_WIDTH'(k)) begin
        cur_valid    = req_valid[k];
        cur_data     = req_data[k*DATA_WIDTH +: DATA_WIDTH];
        req_ready[k] = (state_q == BUSY) && !full;
      end
    end
    wr_valid = (state_q == BUSY) && cur_valid;
    wr_data  = (state_q == BUSY) ? cur_data : '0;
  end

  assign accept    = (state_q == BUSY) && cur_valid && !full;
  assign gnt_valid = (state_q == BUSY);
  assign gnt_id    = gnt_id_q;

`ifdef WR_ARB_BURST_EN
  logic [BURST_CNT_WIDTH-1:0] burst_cnt_q, burst_cnt_d;

  assign burst_done = (32'(burst_cnt_q) + 32'd1 == 32'(MAX_BURST));

  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (state_q == IDLE) begin
      burst_cnt_d = '0;
    end else if (accept) begin
      burst_cnt_d = burst_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      burst_cnt_q <= '0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
    end
  end
`else
  assign burst_done = 1'b1;
`endif

  // A stalled beat (valid high, full high) never releases; a dropped valid
  // always does, even when full is also high.
  always_comb begin
    state_d   = state_q;
    gnt_id_d  = gnt_id_q;
    last_id_d = last_id_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d  = BUSY;
          gnt_id_d = pick_id;
        end
      end
      BUSY: begin
        if (!cur_valid || (accept && burst_done)) begin
          state_d   = IDLE;
          last_id_d = gnt_id_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      state_q   <= IDLE;
      gnt_id_q  <= '0;
      last_id_q <= REQ_IDX_WIDTH'(NUM_REQ - 1);
    end else begin
      state_q   <= state_d;
      gnt_id_q  <= gnt_id_d;
      last_id_q <= last_id_d;
    end
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin arbiter that shares the single write port of the team's async FIFO among NUM_REQ requesters in the write-clock domain. It grants one requester at a time and forwards that requester's valid/data to the FIFO's wr_valid/wr_data. It returns per-requester ready derived from the FIFO full flag. Grants are held for a bounded burst so that no requester can starve the others.

## Interface
- NUM_REQ, 4: number of requesters (2..16).
- REQ_IDX_WIDTH, 2: width of the requester index; must satisfy 2**REQ_IDX_WIDTH >= NUM_REQ.
- DATA_WIDTH, 8: data width; must match the FIFO DATA_WIDTH.
- MAX_BURST, 4: maximum beats per grant (1..2**BURST_CNT_WIDTH-1); used only with burst mode.
- BURST_CNT_WIDTH, 3: width of the burst counter.
- wr_clk  in  1  single clock, the FIFO write-side clock; all logic is rising-edge.
- wr_rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester data valid.
- req_data  in  NUM_REQ*DATA_WIDTH  packed data; requester k occupies [k*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- full  in  1  FIFO full flag.
- wr_valid  out  1  to FIFO wr_valid.
- wr_data  out  DATA_WIDTH  to FIFO wr_data.
- gnt_valid  out  1  a grant is held (state BUSY).
- gnt_id  out  REQ_IDX_WIDTH  index of the granted requester.

## Operation
- States:
  - IDLE: no grant.
  - BUSY: grant held by gnt_id.
- Registers: state, gnt_id, last_id (last released requester), burst_cnt.
- IDLE:
  - If any req_valid bit is set, select the first set bit searching upward from last_id+1 modulo NUM_REQ.
  - Register the selection into gnt_id and clear burst_cnt.
  - Next state is BUSY.
  - If no request is pending, stay in IDLE.
- BUSY outputs:
  - wr_valid = req_valid[gnt_id].
  - wr_data = req_data[gnt_id].
  - req_ready[gnt_id] = !full; all other ready bits are 0.
- Beat accepted: req_valid[gnt_id] && !full. The FIFO write enable is exactly wr_valid && !full.
- Release from BUSY to IDLE, with last_id <= gnt_id, when either:
  - req_valid[gnt_id] is low in a cycle (the requester went idle), or
  - an accepted beat completes the burst limit.
- full high while req_valid[gnt_id] is high: hold BUSY and do not count a beat. Stalls never release the grant.
- Outside BUSY: wr_valid = 0, wr_data = 0, req_ready = 0.
- burst_cnt increments per accepted beat. Index arithmetic wraps at NUM_REQ, not at 2**REQ_IDX_WIDTH.
- Requests from indices >= NUM_REQ do not exist; the search never visits them.
- Data integrity: an accepted beat is written to the FIFO exactly once, and beats from one requester keep their order.

## Timing
- Reset values:
  - state IDLE, gnt_valid 0, gnt_id 0.
  - last_id NUM_REQ-1, so requester 0 has top priority after reset.
  - burst_cnt 0, req_ready 0, wr_valid 0, wr_data 0.
- Arbitration latency: a request seen in IDLE at cycle N gets gnt_valid and req_ready at cycle N+1; the first beat can be accepted at N+1.
- Each release costs one IDLE bubble cycle before the next grant.
- Outputs in BUSY are combinational from the registered gnt_id, req_valid, req_data and full. There is no registered datapath, so data has zero latency to the FIFO.
- Simultaneous events:
  - Final burst beat accepted while others are waiting: release takes priority; the next winner is chosen in the following IDLE cycle.
  - Valid drop and full in the same cycle: this is a release.
- Reset asserted mid-burst: next edge forces IDLE and reset values. A partially sent burst is abandoned; beats already accepted remain in the FIFO.

## Configuration
- WR_ARB_BURST_EN defined: release when the accepted beat brings burst_cnt+1 to MAX_BURST. Sustained throughput is MAX_BURST beats per MAX_BURST+1 cycles.
- WR_ARB_BURST_EN undefined:
  - Release after every accepted beat. The effective burst is 1, giving one beat per 2 cycles.
  - burst_cnt and the MAX_BURST comparison are not built.

## Test plan
- Reset priority: deassert wr_rst with req_valid=4'b1111 and full=0 -> cycle 1 gnt_id=0. With the macro, grants proceed 0,1,2,3,0, each accepting 4 beats with one bubble. Without the macro, each grant accepts 1 beat.
- Full stall: requester 2 granted, full=1 for 5 cycles -> wr_valid=1, req_ready=0, gnt_id stays 2, no beat counted. After full=0 it resumes with an unchanged burst count, and no beat is lost or duplicated.
- Early release: requester 1 granted, sends 2 beats (0xA1, 0xA2) then drops valid -> release; last_id=1. With req_valid=4'b1001 pending, the next grant goes to 3, then 0.
- Fairness: all 4 requesters stream continuously for 200 cycles with the macro -> each accepts 40 beats ±4, and FIFO data arrives in per-requester order.
- Reset mid-burst: assert wr_rst during beat 2 of a burst -> next cycle all outputs are 0 and state is IDLE. The following grant goes to requester 0.
- Non-power-of-2 NUM_REQ=3: with last_id=2, the search wraps to 0, never index 3. Check req_ready stays one-hot or zero in every cycle.
